// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types, CRC5 constants and helpers for the USB token transmitter
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'h1,
        PID_SOF   = 4'h5,
        PID_IN    = 4'h9,
        PID_SETUP = 4'hD
    } pid_t;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SEND_PID,
        ST_SEND_B1,
        ST_SEND_B2
    } tok_state_t;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) || (pid == PID_SETUP);
    endfunction

    // Wire order is LSB first, so the register is bit-reversed and inverted.
    function automatic logic [4:0] crc5_field(input logic [4:0] crc);
        return ~{crc[0], crc[1], crc[2], crc[3], crc[4]};
    endfunction

endpackage

// File: rtl/crc5_serial.sv
// rtl/crc5_serial.sv - bit-serial CRC5 LFSR
// Ports: clk, n_rst (sync active-high), clr (reload seed), en (shift one bit),
//        din (payload bit), crc[4:0] (current register value)
module crc5_serial #(
    parameter logic [4:0] POLY = 5'b00101,
    parameter logic [4:0] INIT = 5'b11111
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [4:0] crc
);

    logic [4:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[4] ^ din;
    assign crc  = r_crc;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_crc <= INIT;
        end else if (clr) begin
            r_crc <= INIT;
        end else if (en) begin
            r_crc <= {r_crc[3:0], 1'b0} ^ (w_fb ? POLY : 5'b00000);
        end
    end

endmodule

// File: rtl/usb_token_tx.sv
// rtl/usb_token_tx.sv - builds 3-byte USB token packets with serial CRC5
// Ports: clk, n_rst (sync active-high); token request tok_valid/tok_ready/
//        tok_pid/tok_addr/tok_endp; byte stream tx_data/tx_valid/tx_ready/
//        tx_last; pid_err one-cycle pulse on an illegal PID.
module usb_token_tx #(
    parameter logic [4:0] CRC5_POLY = 5'b00101,
    parameter logic [4:0] CRC5_INIT = 5'b11111
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic [3:0] tok_pid,
    input  logic [6:0] tok_addr,
    input  logic [3:0] tok_endp,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       pid_err
);
    import usb_pkg::*;

    tok_state_t  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic        r_tok_ready;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic        r_pid_err;

    logic        w_accept;
    logic [10:0] w_payload;
    logic [4:0]  w_crc;

    assign w_accept  = (r_state == ST_IDLE) && tok_valid && r_tok_ready && is_token_pid(tok_pid);
    assign w_payload = {r_endp, r_addr};

    // Seeded on the accept edge; shifts once per CALC cycle, addr[0] first.
    crc5_serial #(
        .POLY (CRC5_POLY),
        .INIT (CRC5_INIT)
    ) u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (w_accept),
        .en    (r_state == ST_CALC),
        .din   (w_payload[r_cnt]),
        .crc   (w_crc)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_pid       <= 4'd0;
            r_addr      <= 7'd0;
            r_endp      <= 4'd0;
            r_tok_ready <= 1'b0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_pid_err   <= 1'b0;
        end else begin
            r_pid_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tok_ready <= 1'b1;
                    if (tok_valid && r_tok_ready) begin
                        if (is_token_pid(tok_pid)) begin
                            r_pid       <= tok_pid;
                            r_addr      <= tok_addr;
                            r_endp      <= tok_endp;
                            r_cnt       <= 4'd0;
                            r_tok_ready <= 1'b0;
                            r_state     <= ST_CALC;
                        end else begin
                            r_pid_err <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        r_tx_data  <= {~r_pid, r_pid};
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND_PID;
                    end
                end
                ST_SEND_PID: begin
                    if (tx_ready) begin
                        r_tx_data <= {r_endp[0], r_addr};
                        r_state   <= ST_SEND_B1;
                    end
                end
                ST_SEND_B1: begin
                    // CRC has been final since the last CALC edge.
                    if (tx_ready) begin
                        r_tx_data <= {crc5_field(w_crc), r_endp[3:1]};
                        r_tx_last <= 1'b1;
                        r_state   <= ST_SEND_B2;
                    end
                end
                ST_SEND_B2: begin
                    if (tx_ready) begin
                        r_tx_data   <= 8'd0;
                        r_tx_valid  <= 1'b0;
                        r_tx_last   <= 1'b0;
                        r_tok_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tok_ready = r_tok_ready;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_last   = r_tx_last;
    assign pid_err   = r_pid_err;

endmodule

// File: tb/tb_usb_token_tx.sv
// tb/tb_usb_token_tx.sv - self-checking bench for usb_token_tx
module tb_usb_token_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_pid;
    logic [6:0] tok_addr;
    logic [3:0] tok_endp;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       pid_err;

    usb_token_tx dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_pid   (tok_pid),
        .tok_addr  (tok_addr),
        .tok_endp  (tok_endp),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .pid_err   (pid_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [2:0] b2_lo;
        int         crc;   // -1: take CRC from the reference model
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: five-cycle stall per byte

    logic       hold_pending = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;

    // Reflected-form USB CRC5 (poly 0x14, LSB first), result already complemented.
    function automatic logic [4:0] ref_crc_field(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] bits;
        logic [4:0]  r;
        bits = {e, a};
        r = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (r[0] ^ bits[i]) r = (r >> 1) ^ 5'h14;
            else                r = r >> 1;
        end
        return ~r;
    endfunction

    function automatic logic legal_pid(input logic [3:0] p);
        case (p)
            4'h1, 4'h5, 4'h9, 4'hD: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        sb.push_back('{data: b0, last: 1'b0});
        sb.push_back('{data: b1, last: 1'b0});
        sb.push_back('{data: b2, last: 1'b1});
    endtask

    task automatic push_model(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        push_packet({~p, p}, {e[0], a}, {ref_crc_field(a, e), e[3:1]});
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        int n = 0;
        while (!tok_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("tok_ready_wait", {31'd0, tok_ready}, 32'd1);
        tok_valid = 1'b1;
        tok_pid   = p;
        tok_addr  = a;
        tok_endp  = e;
        @(posedge clk); #1;
        tok_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !tok_ready) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("drain_queue_empty", sb.size(), 0);
        check("drain_tok_ready", {31'd0, tok_ready}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_tx_last"}, {31'd0, tx_last}, 32'd0);
        check({tag, "_pid_err"}, {31'd0, pid_err}, 32'd0);
        check({tag, "_tok_ready"}, {31'd0, tok_ready}, 32'd0);
    endtask

    // tx_ready driver
    initial begin : ready_drv
        int  stall;
        logic hs;
        stall = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            hs = tx_valid && tx_ready;
            #1;
            if (ready_mode == 0) begin
                tx_ready = 1'b1;
            end else if (ready_mode == 1) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (hs || !tx_valid) stall = 0;
                else                 stall++;
                tx_ready = (stall >= 6);
            end
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (n_rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!(tx_valid && tx_data == hold_data && tx_last == hold_last)) begin
                    failures++;
                    $display("FAIL stall_hold got=%b/%h/%b exp=1/%h/%b", tx_valid, tx_data, tx_last, hold_data, hold_last);
                end
            end
            if (tx_valid) begin
                checks++;
                if (tok_ready) begin
                    failures++;
                    $display("FAIL tok_ready_busy got=1 exp=0");
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte got=%h exp=none", tx_data);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    if (tx_data !== x.data || tx_last !== x.last) begin
                        failures++;
                        $display("FAIL byte got=%h last=%b exp=%h last=%b", tx_data, tx_last, x.data, x.last);
                    end
                end
            end
            hold_pending = tx_valid && !tx_ready;
            hold_data    = tx_data;
            hold_last    = tx_last;
        end
    end

    initial begin : main
        vec_t vecs[5];
        int   n;

        vecs[0] = '{pid: 4'hD, addr: 7'h00, endp: 4'h0, b0: 8'h2D, b1: 8'h00, b2_lo: 3'b000, crc: 2};
        vecs[1] = '{pid: 4'h9, addr: 7'h7F, endp: 4'hF, b0: 8'h69, b1: 8'hFF, b2_lo: 3'b111, crc: -1};
        vecs[2] = '{pid: 4'h1, addr: 7'h05, endp: 4'h2, b0: 8'hE1, b1: 8'h05, b2_lo: 3'b001, crc: -1};
        vecs[3] = '{pid: 4'h5, addr: 7'h2A, endp: 4'h9, b0: 8'hA5, b1: 8'hAA, b2_lo: 3'b100, crc: -1};
        vecs[4] = '{pid: 4'h1, addr: 7'h01, endp: 4'h8, b0: 8'hE1, b1: 8'h01, b2_lo: 3'b100, crc: -1};

        n_rst = 1'b1;
        tok_valid = 1'b0;
        tok_pid = 4'h0;
        tok_addr = 7'h0;
        tok_endp = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        n_rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release_tok_ready", {31'd0, tok_ready}, 32'd1);

        // Table vectors, tx_ready always high
        ready_mode = 0;
        foreach (vecs[i]) begin
            logic [4:0] crc;
            crc = (vecs[i].crc < 0) ? ref_crc_field(vecs[i].addr, vecs[i].endp) : vecs[i].crc[4:0];
            push_packet(vecs[i].b0, vecs[i].b1, {crc, vecs[i].b2_lo});
            send_token(vecs[i].pid, vecs[i].addr, vecs[i].endp);
            if (i == 0) begin
                // accept cycle plus 11 CALC cycles, then byte 0
                n = 0;
                while (!tx_valid && n < 50) begin
                    @(posedge clk); #1; n++;
                end
                check("latency_edges", n, 11);
            end
            drain();
        end

        // Stall five cycles on every byte
        ready_mode = 2;
        push_model(4'h9, 7'h7F, 4'hF);
        send_token(4'h9, 7'h7F, 4'hF);
        drain();
        push_model(4'hD, 7'h33, 4'h6);
        send_token(4'hD, 7'h33, 4'h6);
        drain();

        // Illegal PIDs: one pid_err pulse each, nothing transmitted
        ready_mode = 0;
        for (int p = 0; p < 16; p++) begin
            if (!legal_pid(4'(p))) begin
                tok_valid = 1'b1;
                tok_pid   = 4'(p);
                @(posedge clk); #1;
                tok_valid = 1'b0;
                check("pid_err_pulse", {31'd0, pid_err}, 32'd1);
                check("pid_err_tok_ready", {31'd0, tok_ready}, 32'd1);
                @(posedge clk); #1;
                check("pid_err_clear", {31'd0, pid_err}, 32'd0);
                check("pid_err_no_tx", {31'd0, tx_valid}, 32'd0);
            end
        end

        // Reset in CALC with cnt==5
        push_model(4'h1, 7'h12, 4'h3);
        send_token(4'h1, 7'h12, 4'h3);
        repeat (5) @(posedge clk);
        #1;
        n_rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check_idle_outputs("rst_calc");
        n_rst = 1'b0;
        push_model(4'h9, 7'h44, 4'hA);
        send_token(4'h9, 7'h44, 4'hA);
        drain();

        // Reset while byte 1 is on the bus
        push_model(4'h5, 7'h5A, 4'h7);
        send_token(4'h5, 7'h5A, 4'h7);
        repeat (12) @(posedge clk);
        #1;
        check("b1_present", {24'd0, tx_data}, {24'd0, 4'h7 & 4'h1, 7'h5A});
        n_rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check_idle_outputs("rst_b1");
        n_rst = 1'b0;
        push_model(4'hD, 7'h01, 4'h1);
        send_token(4'hD, 7'h01, 4'h1);
        drain();

        // Random legal tokens with random backpressure
        ready_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            logic [3:0] p;
            logic [6:0] a;
            logic [3:0] e;
            case ($urandom_range(0, 3))
                0:       p = 4'h1;
                1:       p = 4'h9;
                2:       p = 4'h5;
                default: p = 4'hD;
            endcase
            a = 7'($urandom_range(0, 127));
            e = 4'($urandom_range(0, 15));
            // tok_ready only returns once the previous packet has fully left
            push_model(p, a, e);
            send_token(p, a, e);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
